// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 definitions.
//   SBOX       - 256x8 S-box table, SBOX[x] is the substitution of byte x
//   SM4_ROUNDS - number of rounds per block (32)
//   state_e    - core FSM states
//   l_xform()  - linear transform L used by the round function T
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned RND_W      = $clog2(SM4_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Index 0 is the most significant byte, so each 128-bit row holds 16 entries.
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // 32-bit rotate left; n is always a constant between 1 and 31.
  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] b, input int unsigned n);
    return (b << n) | (b >> (WORD_W - n));
  endfunction

  // Round-function linear layer.
  function automatic logic [WORD_W-1:0] l_xform(input logic [WORD_W-1:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

endpackage

// File: rtl/sm4_tfunc.sv
// sm4_tfunc: combinational SM4 round function T = L(tau(x)).
//   x   - 32-bit input word
//   t_c - 32-bit T output (combinational)
module sm4_tfunc
  import sm4_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] t_c
);

  logic [WORD_W-1:0] tau;

  // Four parallel S-box lookups followed by the linear layer.
  always_comb begin
    tau = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    t_c = l_xform(tau);
  end

endmodule

// File: rtl/sm4_core.sv
// sm4_core: iterative SM4 block cipher datapath, one round per consumed key.
//   clk_sys, sys_rst          - clock, synchronous active-high reset
//   sm4_start                 - new key session: aborts block, clears key state
//   sm4_data_in/_vld/_rdy     - input block handshake (X0 in [127:96])
//   key2core_rkey/_vld        - round keys rk0..rk31, no back-pressure
//   core_data_out/_vld        - result block (Y0 in [127:96]) and 1-cycle strobe
//   core_key_err              - 1-cycle pulse for a round key that cannot be used
// Build option SM4_RKEY_BUF_EN: store the 32 round keys locally so blocks run
// one round per cycle and can be issued back-to-back; otherwise rounds follow
// the incoming key strobes directly.
module sm4_core
  import sm4_pkg::*;
(
  input  logic               clk_sys,
  input  logic               sys_rst,
  input  logic               sm4_start,
  input  logic [BLOCK_W-1:0] sm4_data_in,
  input  logic               sm4_data_in_vld,
  output logic               sm4_data_in_rdy,
  input  logic [WORD_W-1:0]  key2core_rkey,
  input  logic               key2core_rkey_vld,
  output logic [BLOCK_W-1:0] core_data_out,
  output logic               core_data_out_vld,
  output logic               core_key_err
);

  state_e             state_q, state_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] dout_d;
  logic               vld_d, err_d, rdy_d;
  logic               accept, round_en;
  logic [WORD_W-1:0]  rk, t_in, t_out, round_word;

  assign accept = sm4_data_in_vld && sm4_data_in_rdy;

`ifdef SM4_RKEY_BUF_EN
  logic [WORD_W-1:0] rkey_buf [SM4_ROUNDS];
  logic [RND_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              buf_wr;

  assign buf_wr   = key2core_rkey_vld && !full_q && !sm4_start && !sys_rst;
  assign rk       = rkey_buf[rnd_q];
  assign round_en = 1'b1;

  // Key storage needs no reset: entries are only read once the fill count says they are valid.
  always_ff @(posedge clk_sys) begin
    if (buf_wr) rkey_buf[cnt_q] <= key2core_rkey;
  end
`else
  assign rk       = key2core_rkey;
  assign round_en = key2core_rkey_vld;
`endif

  // Block register holds {X(i), X(i+1), X(i+2), X(i+3)} before round i.
  assign t_in       = blk_q[95:64] ^ blk_q[63:32] ^ blk_q[31:0] ^ rk;
  assign round_word = blk_q[127:96] ^ t_out;

  sm4_tfunc u_tfunc (
    .x   (t_in),
    .t_c (t_out)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    dout_d  = core_data_out;
    vld_d   = 1'b0;
    err_d   = 1'b0;
`ifdef SM4_RKEY_BUF_EN
    cnt_d   = cnt_q;
    full_d  = full_q;
`endif
    if (sm4_start) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
`ifdef SM4_RKEY_BUF_EN
      cnt_d   = '0;
      full_d  = 1'b0;
`endif
    end else begin
`ifdef SM4_RKEY_BUF_EN
      if (key2core_rkey_vld) begin
        if (full_q) begin
          err_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + RND_W'(1);
          full_d = (cnt_q == RND_W'(SM4_ROUNDS - 1));
        end
      end
`else
      err_d = key2core_rkey_vld && (state_q != ST_ROUND);
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_ROUND;
            rnd_d   = '0;
            blk_d   = sm4_data_in;
          end
        end
        ST_ROUND: begin
          if (round_en) begin
            blk_d = {blk_q[95:0], round_word};
            rnd_d = rnd_q + RND_W'(1);
            // Last round: emit the word-reversed block {X35, X34, X33, X32}.
            if (rnd_q == RND_W'(SM4_ROUNDS - 1)) begin
              state_d = ST_DONE;
              dout_d  = {round_word, blk_q[31:0], blk_q[63:32], blk_q[95:64]};
              vld_d   = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef SM4_RKEY_BUF_EN
    rdy_d = (state_d == ST_IDLE) && full_d;
`else
    rdy_d = (state_d == ST_IDLE);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (sys_rst) begin
      state_q           <= ST_IDLE;
      rnd_q             <= '0;
      blk_q             <= '0;
      core_data_out     <= '0;
      core_data_out_vld <= 1'b0;
      core_key_err      <= 1'b0;
      sm4_data_in_rdy   <= 1'b0;
`ifdef SM4_RKEY_BUF_EN
      cnt_q             <= '0;
      full_q            <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      rnd_q             <= rnd_d;
      blk_q             <= blk_d;
      core_data_out     <= dout_d;
      core_data_out_vld <= vld_d;
      core_key_err      <= err_d;
      sm4_data_in_rdy   <= rdy_d;
`ifdef SM4_RKEY_BUF_EN
      cnt_q             <= cnt_d;
      full_q            <= full_d;
`endif
    end
  end

endmodule

// File: tb/tb_sm4_core.sv
// tb_sm4_core: directed self-checking bench for sm4_core using the GB/T 32907
// example key/plaintext; covers either build of SM4_RKEY_BUF_EN.
`timescale 1ns/1ps
module tb_sm4_core;
  import sm4_pkg::*;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk_sys           = 1'b0;
  logic         sys_rst           = 1'b1;
  logic         sm4_start         = 1'b0;
  logic [127:0] sm4_data_in       = '0;
  logic         sm4_data_in_vld   = 1'b0;
  logic         sm4_data_in_rdy;
  logic [31:0]  key2core_rkey     = '0;
  logic         key2core_rkey_vld = 1'b0;
  logic [127:0] core_data_out;
  logic         core_data_out_vld;
  logic         core_key_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  logic [127:0] out_q [$];
  int           cyc_q [$];
  logic [31:0]  rk [32];

  sm4_core dut (
    .clk_sys           (clk_sys),
    .sys_rst           (sys_rst),
    .sm4_start         (sm4_start),
    .sm4_data_in       (sm4_data_in),
    .sm4_data_in_vld   (sm4_data_in_vld),
    .sm4_data_in_rdy   (sm4_data_in_rdy),
    .key2core_rkey     (key2core_rkey),
    .key2core_rkey_vld (key2core_rkey_vld),
    .core_data_out     (core_data_out),
    .core_data_out_vld (core_data_out_vld),
    .core_key_err      (core_key_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Record every result pulse with the cycle it appeared in, and count key errors.
  always @(negedge clk_sys) begin
    if (core_data_out_vld === 1'b1) begin
      out_q.push_back(core_data_out);
      cyc_q.push_back(cyc);
    end
    if (core_key_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    sm4_start = 1'b1;
    tick();
    sm4_start = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] k);
    key2core_rkey     = k;
    key2core_rkey_vld = 1'b1;
    tick();
    key2core_rkey_vld = 1'b0;
  endtask

  // Presents a block once rdy is up; t is the cycle the handshake was presented in.
  task automatic send_block(input logic [127:0] d, output int t);
    int n;
    n = 0;
    while (sm4_data_in_rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("rdy_before_accept", sm4_data_in_rdy, 1'b1);
    sm4_data_in     = d;
    sm4_data_in_vld = 1'b1;
    t               = cyc;
    tick();
    sm4_data_in_vld = 1'b0;
  endtask

  task automatic wait_pulse(input int target, input int budget);
    int n;
    n = 0;
    while (out_q.size() < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dout"}, core_data_out, '0);
    check({tag, "_vld"}, core_data_out_vld, 1'b0);
    check({tag, "_err"}, core_key_err, 1'b0);
    check({tag, "_rdy"}, sm4_data_in_rdy, 1'b0);
  endtask

  task automatic check_result(input string tag, input int idx, input int t, input int lat,
                              input logic [127:0] exp);
    logic [127:0] got_data;
    int           got_lat;
    got_data = '0;
    got_lat  = -1;
    if (out_q.size() > idx) begin
      got_data = out_q[idx];
      got_lat  = cyc_q[idx] - t;
    end
    check({tag, "_data"}, got_data, exp);
    check({tag, "_lat"}, got_lat, lat);
  endtask

  // Key-schedule reference so the streamed round keys come from the key itself.
  function automatic logic [31:0] tprime(input logic [31:0] b);
    logic [31:0] s;
    s = {SBOX[b[31:24]], SBOX[b[23:16]], SBOX[b[15:8]], SBOX[b[7:0]]};
    return s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
  endfunction

  task automatic expand_keys();
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) k[i] = KEY[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk[i]  = k[i+4];
    end
  endtask

`ifdef SM4_RKEY_BUF_EN
  task automatic load_keys(input bit dec, input string tag);
    pulse_start();
    for (int i = 0; i < 31; i++) send_key(dec ? rk[31-i] : rk[i]);
    check({tag, "_rdy_31keys"}, sm4_data_in_rdy, 1'b0);
    send_key(dec ? rk[0] : rk[31]);
    check({tag, "_rdy_32keys"}, sm4_data_in_rdy, 1'b1);
  endtask

  task automatic run_buf(input logic [127:0] din, input logic [127:0] exp, input string tag);
    int t, s0, e0;
    s0 = out_q.size();
    e0 = err_cnt;
    send_block(din, t);
    wait_pulse(s0 + 1, 50);
    repeat (2) tick();
    check_result(tag, s0, t, 33, exp);
    check({tag, "_npulse"}, out_q.size() - s0, 1);
    check({tag, "_keyerr"}, err_cnt - e0, 0);
    check({tag, "_hold"}, core_data_out, exp);
  endtask
`else
  task automatic run_unbuf(input logic [127:0] din, input bit dec, input int gap_len,
                           input logic [127:0] exp, input string tag);
    int t, s0, e0;
    pulse_start();
    s0 = out_q.size();
    e0 = err_cnt;
    send_block(din, t);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) repeat (gap_len) tick();
      send_key(dec ? rk[31-i] : rk[i]);
    end
    wait_pulse(s0 + 1, 20);
    repeat (2) tick();
    check_result(tag, s0, t, 33 + gap_len, exp);
    check({tag, "_npulse"}, out_q.size() - s0, 1);
    check({tag, "_keyerr"}, err_cnt - e0, 0);
    check({tag, "_hold"}, core_data_out, exp);
  endtask
`endif

  initial begin
    int t0, t1, t2, s0, e0;
    expand_keys();
    check("rk0", rk[0], 32'hf12186f9);
    check("rk31", rk[31], 32'h9124a012);

    tick();
    check_zero_outputs("reset");
    sys_rst = 1'b0;
    tick();

`ifdef SM4_RKEY_BUF_EN
    check("rdy_empty_after_reset", sm4_data_in_rdy, 1'b0);
    load_keys(1'b0, "load");

    // 33rd key while full: flagged and ignored.
    e0 = err_cnt;
    send_key(32'hdeadbeef);
    check("key33_err", core_key_err, 1'b1);
    tick();
    check("key33_err_pulse", core_key_err, 1'b0);
    check("key33_rdy", sm4_data_in_rdy, 1'b1);
    check("key33_err_count", err_cnt - e0, 1);
    run_buf(PT, CT, "std");

    // Three blocks back-to-back on one key load.
    s0 = out_q.size();
    e0 = err_cnt;
    send_block(PT, t0);
    check("b2b_rdy_round_start", sm4_data_in_rdy, 1'b0);
    repeat (16) tick();
    check("b2b_rdy_round_mid", sm4_data_in_rdy, 1'b0);
    send_block(PT, t1);
    send_block(PT, t2);
    wait_pulse(s0 + 3, 60);
    repeat (2) tick();
    check("b2b_npulse", out_q.size() - s0, 3);
    check("b2b_spacing1", t1 - t0, 34);
    check("b2b_spacing2", t2 - t1, 34);
    check_result("b2b0", s0, t0, 33, CT);
    check_result("b2b1", s0 + 1, t1, 33, CT);
    check_result("b2b2", s0 + 2, t2, 33, CT);
    check("b2b_keyerr", err_cnt - e0, 0);

    load_keys(1'b1, "dec_load");
    run_buf(CT, PT, "dec");

    // Abort at rnd=15.
    load_keys(1'b0, "abort_load");
    s0 = out_q.size();
    send_block(PT, t0);
    repeat (15) tick();
    pulse_start();
    check("abort_rdy_next", sm4_data_in_rdy, 1'b0);
    repeat (40) tick();
    check("abort_npulse", out_q.size() - s0, 0);
    check("abort_rdy_held", sm4_data_in_rdy, 1'b0);
    load_keys(1'b0, "abort_reload");

    // Reset at rnd=20 with a key strobe in the same cycle.
    s0 = out_q.size();
    send_block(PT, t0);
    repeat (20) tick();
    sys_rst           = 1'b1;
    key2core_rkey     = rk[3];
    key2core_rkey_vld = 1'b1;
    tick();
    sys_rst           = 1'b0;
    key2core_rkey_vld = 1'b0;
    check_zero_outputs("mid_rst");
    repeat (40) tick();
    check("mid_rst_npulse", out_q.size() - s0, 0);
    check("mid_rst_rdy_empty", sm4_data_in_rdy, 1'b0);
    load_keys(1'b0, "post_rst_load");
    run_buf(PT, CT, "post_rst");
`else
    check("rdy_after_reset", sm4_data_in_rdy, 1'b1);
    run_unbuf(PT, 1'b0, 0, CT, "std");
    run_unbuf(PT, 1'b0, 3, CT, "gap");
    run_unbuf(CT, 1'b1, 0, PT, "dec");

    // Abort at rnd=15.
    pulse_start();
    s0 = out_q.size();
    e0 = err_cnt;
    send_block(PT, t0);
    for (int i = 0; i < 15; i++) send_key(rk[i]);
    check("abort_rdy_in_round", sm4_data_in_rdy, 1'b0);
    pulse_start();
    check("abort_rdy_next", sm4_data_in_rdy, 1'b1);
    repeat (40) tick();
    check("abort_npulse", out_q.size() - s0, 0);
    check("abort_keyerr", err_cnt - e0, 0);

    // Stray key in IDLE.
    e0 = err_cnt;
    send_key(32'hdeadbeef);
    check("stray_err", core_key_err, 1'b1);
    tick();
    check("stray_err_pulse", core_key_err, 1'b0);
    check("stray_rdy", sm4_data_in_rdy, 1'b1);
    check("stray_err_count", err_cnt - e0, 1);

    // Reset at rnd=20 with a key strobe in the same cycle.
    pulse_start();
    s0 = out_q.size();
    send_block(PT, t0);
    for (int i = 0; i < 20; i++) send_key(rk[i]);
    sys_rst           = 1'b1;
    key2core_rkey     = rk[20];
    key2core_rkey_vld = 1'b1;
    tick();
    sys_rst           = 1'b0;
    key2core_rkey_vld = 1'b0;
    check_zero_outputs("mid_rst");
    tick();
    check("mid_rst_rdy_idle", sm4_data_in_rdy, 1'b1);
    repeat (20) tick();
    check("mid_rst_npulse", out_q.size() - s0, 0);
    run_unbuf(PT, 1'b0, 0, CT, "post_rst");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_core.md
SM4_CORE -- requirements
Module: sm4_core

Interface
REQ-001 SHALL provide clk_sys, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide sys_rst, input, 1, synchronous active-high reset.
REQ-003 SHALL provide sm4_start, input, 1, a one-cycle pulse that marks a new key session; it is the same pulse sent to the key schedule.
REQ-004 SHALL provide sm4_data_in, input, 128, the input block, word X0 in bits [127:96].
REQ-005 SHALL provide sm4_data_in_vld, input, 1; a block is accepted when sm4_data_in_vld and sm4_data_in_rdy are both high on a rising edge.
REQ-006 SHALL provide sm4_data_in_rdy, output, 1, high only in IDLE, and only when keys are available (see REQ-017).
REQ-007 SHALL provide key2core_rkey, input, 32, the round key rk_i, delivered in order i=0..31.
REQ-008 SHALL provide key2core_rkey_vld, input, 1, round-key strobe; the core cannot back-pressure it.
REQ-009 SHALL provide core_data_out, output, 128, the result block, Y0 in bits [127:96]; it holds its value until the next result.
REQ-010 SHALL provide core_data_out_vld, output, 1, a one-cycle result pulse.
REQ-011 SHALL provide core_key_err, output, 1, a one-cycle pulse when a round key arrives that cannot be consumed.

Function
REQ-012 SHALL implement states IDLE, ROUND and DONE, plus a 5-bit round counter rnd.
- IDLE -> ROUND on data accept.
- ROUND -> DONE when the round using rk31 completes.
- DONE -> IDLE after exactly one cycle.
REQ-013 SHALL perform one round per consumed key: X(i+4) = X(i) ^ T(X(i+1)^X(i+2)^X(i+3)^rk_i).
- T = L(tau(B)); tau is four parallel S-box lookups.
- L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
- All arithmetic is 32-bit XOR and rotate; there is no carry.
REQ-014 SHALL apply the reverse transform on output: core_data_out = {X35,X34,X33,X32}, registered and driven in DONE together with core_data_out_vld=1.
REQ-015 SHALL, on sm4_start, abort any block in progress and return to IDLE next cycle.
- No output pulse is produced for the aborted block.
- rnd is cleared.
- Key-buffer state is cleared (REQ-017).
- If sm4_start and a data accept occur in the same cycle, sm4_start wins and the data is dropped.
REQ-016 SHALL, when rnd wraps from 31 to 0, always leave ROUND; there is no 33rd round.

Reset
REQ-018 SHALL, under sys_rst, force the following on the next edge:
- state=IDLE, rnd=0;
- core_data_out=128'h0, core_data_out_vld=0, core_key_err=0, sm4_data_in_rdy=0;
- buffer fill count=0, buffer-full flag=0.
REQ-019 SHALL give sys_rst priority over sm4_start, the data handshake and key2core_rkey_vld.

Configuration
REQ-017 SHALL honour the macro SM4_RKEY_BUF_EN.
- Defined: keys go into a 32x32 register buffer.
  - Each key2core_rkey_vld writes entry[cnt] and increments cnt.
  - The buffer-full flag sets after 32 writes.
  - sm4_data_in_rdy = IDLE && full.
  - ROUND reads entry[rnd], one round every cycle; latency from accept at cycle T to core_data_out_vld is T+33.
  - Blocks may be issued back-to-back without reloading keys.
  - A key strobe while the buffer is full pulses core_key_err, and the key is ignored.
- Undefined: there is no buffer.
  - sm4_data_in_rdy = IDLE.
  - ROUND advances only on cycles where key2core_rkey_vld=1 and holds otherwise.
  - core_data_out_vld asserts the cycle after rk31 is consumed.
  - A key strobe while in IDLE or DONE pulses core_key_err, and the key is dropped.
  - Each block requires a new sm4_start and key stream.

Structure
REQ-020 SHALL place the following in package sm4_pkg:
- the 256x8 S-box constant table;
- the SM4_ROUNDS=32 constant;
- the state enum typedef;
- the L-transform function.
REQ-021 SHALL contain one combinational sub-module, sm4_tfunc (32-bit in to 32-bit T out), instanced once.

Verification
REQ-022 Standard vector, buffer enabled:
- Stimulus: sm4_start; key 0123456789abcdeffedcba9876543210 streamed with rk0=f12186f9 and rk31=9124a012; after full, send plaintext 0123456789abcdeffedcba9876543210.
- Required response: core_data_out=681edf34d206965e86b3e94f536e4246 with a single core_data_out_vld pulse 33 cycles after accept.
REQ-023 Same vector, buffer disabled:
- Stimulus: data accepted before rk0; key2core_rkey_vld gapped by 3 idle cycles at rnd=10.
- Required response: same ciphertext; the pulse is delayed 3 cycles; no core_key_err.
REQ-024 Back-to-back, buffer enabled:
- Stimulus: 3 blocks accepted at T, T+34, T+68.
- Required response: 3 pulses with correct ciphertexts; sm4_data_in_rdy=0 throughout ROUND.
REQ-025 Abort:
- Stimulus: sm4_start at rnd=15.
- Required response: no core_data_out_vld; state IDLE next cycle; sm4_data_in_rdy=0 until 32 new keys arrive (buffer enabled).
REQ-026 Reset mid-round:
- Stimulus: sys_rst high at rnd=20.
- Required response: all outputs 0 on the next edge; a following standard-vector run passes.
REQ-027 Stray key:
- Stimulus: key2core_rkey_vld in IDLE (buffer disabled), or a 33rd key (buffer enabled).
- Required response: a one-cycle core_key_err pulse; state unchanged.
